// File: rtl/inst_rom_ctrl.sv
// -----------------------------------------------------------------------------
// inst_rom_ctrl
//   Instruction-memory responder at the ROM end of the fetch interface.
//   Returns the instruction word for the fetch address with a fixed 1-cycle
//   registered latency. A valid/ready program-load port fills the array at
//   runtime. While loading, the core is held through the pipeline controller,
//   and a single-cycle core restart pulse is issued when the load completes.
//
//   Optional build macro: IROM_RANGE_CHK_EN
//     defined   : misaligned or out-of-range fetches return NOP, invalid,
//                 fetch_err_o=1
//     undefined : low address bits ignored, index wraps modulo DEPTH,
//                 fetch_err_o stays 0
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   inst_addr_i    fetch byte address
//   hold_flag_i    pipeline hold; freezes the read outputs
//   inst_o         fetched instruction (registered)
//   inst_valid_o   inst_o holds real memory data
//   fetch_err_o    misaligned/out-of-range fetch (optional feature)
//   ld_start_i     begin a program load
//   ld_valid_i     load word valid
//   ld_data_i      load word
//   ld_last_i      final load word marker
//   ld_ready_o     load word accepted when ld_valid_i & ld_ready_o
//   ld_count_o     words written in the current/last load
//   core_hold_o    stall request during load
//   core_rst_o     1-cycle core restart pulse at load end
//
//   The memory array has no reset; its contents survive rst_n.
// -----------------------------------------------------------------------------
module inst_rom_ctrl #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 4096,
    parameter int unsigned      AW        = 12,
    parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inst_addr_i,
    input  logic             hold_flag_i,
    output logic [WIDTH-1:0] inst_o,
    output logic             inst_valid_o,
    output logic             fetch_err_o,
    input  logic             ld_start_i,
    input  logic             ld_valid_i,
    input  logic [WIDTH-1:0] ld_data_i,
    input  logic             ld_last_i,
    output logic             ld_ready_o,
    output logic [AW:0]      ld_count_o,
    output logic             core_hold_o,
    output logic             core_rst_o
);

    localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        RUN,
        LOAD,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr;
    logic [WIDTH-1:0] offset;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_word;
    logic             rd_err;
    logic             ld_fire;
    logic             ld_final;

    assign offset  = inst_addr_i - BASE_ADDR;
    assign rd_idx  = offset[AW+1:2];
    assign rd_word = mem[rd_idx];

`ifdef IROM_RANGE_CHK_EN
    // Valid fetch window is [BASE_ADDR, BASE_ADDR + 4*DEPTH); addresses below
    // the base wrap to large offsets and fall out of the window too.
    localparam logic [WIDTH:0] SPAN = (WIDTH+1)'(DEPTH) << 2;
    assign rd_err = (offset[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
`else
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[WIDTH-1:AW+2], offset[1:0]};
    assign rd_err = 1'b0;
`endif

    // ld_ready_o is only high in LOAD, so it doubles as the write qualifier.
    assign ld_fire  = ld_valid_i && ld_ready_o;
    assign ld_final = ld_last_i || (wr_ptr == AW'(DEPTH - 1));

    // Array write port: no reset so loaded programs survive rst_n.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem[wr_ptr] <= ld_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wr_ptr       <= '0;
            inst_o       <= NOP;
            inst_valid_o <= 1'b0;
            fetch_err_o  <= 1'b0;
            ld_ready_o   <= 1'b0;
            ld_count_o   <= '0;
            core_hold_o  <= 1'b0;
            core_rst_o   <= 1'b0;
        end else begin
            // Read path: held cycles keep all three read outputs unchanged.
            if (!hold_flag_i) begin
                if (state != RUN) begin
                    inst_o       <= NOP;
                    inst_valid_o <= 1'b0;
                    fetch_err_o  <= 1'b0;
                end else if (rd_err) begin
                    inst_o       <= NOP;
                    inst_valid_o <= 1'b0;
                    fetch_err_o  <= 1'b1;
                end else begin
                    inst_o       <= rd_word;
                    inst_valid_o <= 1'b1;
                    fetch_err_o  <= 1'b0;
                end
            end

            core_rst_o <= 1'b0;

            case (state)
                RUN: begin
                    // A word presented alongside ld_start_i is not written:
                    // ld_ready_o is still low in this cycle.
                    if (ld_start_i) begin
                        state       <= LOAD;
                        wr_ptr      <= '0;
                        ld_count_o  <= '0;
                        core_hold_o <= 1'b1;
                        ld_ready_o  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_fire) begin
                        wr_ptr     <= wr_ptr + AW'(1);
                        ld_count_o <= ld_count_o + (AW+1)'(1);
                        if (ld_final) begin
                            state      <= DONE;
                            ld_ready_o <= 1'b0;
                            core_rst_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state       <= RUN;
                    core_hold_o <= 1'b0;
                end
                default: begin
                    state       <= RUN;
                    ld_ready_o  <= 1'b0;
                    core_hold_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_ctrl
//   Self-checking bench for inst_rom_ctrl with a small array (DEPTH=8) so the
//   capacity limit can be reached. Expected values come from a word-array
//   reference model and a per-load phase tracker.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_rom_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic              clk;
    logic              rst_n;
    logic [WIDTH-1:0]  inst_addr_i;
    logic              hold_flag_i;
    logic [WIDTH-1:0]  inst_o;
    logic              inst_valid_o;
    logic              fetch_err_o;
    logic              ld_start_i;
    logic              ld_valid_i;
    logic [WIDTH-1:0]  ld_data_i;
    logic              ld_last_i;
    logic              ld_ready_o;
    logic [AW:0]       ld_count_o;
    logic              core_hold_o;
    logic              core_rst_o;

    inst_rom_ctrl #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_addr_i (inst_addr_i),
        .hold_flag_i (hold_flag_i),
        .inst_o      (inst_o),
        .inst_valid_o(inst_valid_o),
        .fetch_err_o (fetch_err_o),
        .ld_start_i  (ld_start_i),
        .ld_valid_i  (ld_valid_i),
        .ld_data_i   (ld_data_i),
        .ld_last_i   (ld_last_i),
        .ld_ready_o  (ld_ready_o),
        .ld_count_o  (ld_count_o),
        .core_hold_o (core_hold_o),
        .core_rst_o  (core_rst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_inst;
    logic        exp_valid;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Fetch rule: byte offset from the base selects a word; with range
    // checking, misaligned or beyond-capacity offsets are errors.
    function automatic void ref_read(input logic [31:0] addr, output logic [31:0] inst,
                                     output logic v, output logic e);
        logic [31:0] off;
        off  = addr - BASE;
        inst = model_mem[(off / 4) % DEPTH];
        v    = 1'b1;
        e    = 1'b0;
`ifdef IROM_RANGE_CHK_EN
        if ((off % 4) != 0 || off >= 4 * DEPTH) begin
            inst = NOP;
            v    = 1'b0;
            e    = 1'b1;
        end
`endif
    endfunction

    task automatic check_read(input string tag);
        check({tag, "_inst"},  inst_o,       exp_inst);
        check({tag, "_valid"}, inst_valid_o, exp_valid);
        check({tag, "_err"},   fetch_err_o,  exp_err);
    endtask

    // One RUN-mode cycle: fetch addr (unless held); stray load words ignored.
    task automatic step_run(input logic [31:0] addr, input bit hold, input string tag);
        inst_addr_i = addr;
        hold_flag_i = hold;
        ld_start_i  = 1'b0;
        ld_valid_i  = $urandom_range(0, 1);
        ld_data_i   = $urandom;
        ld_last_i   = $urandom_range(0, 1);
        tick;
        if (!hold) ref_read(addr, exp_inst, exp_valid, exp_err);
        check_read(tag);
        check({tag, "_ready"}, ld_ready_o,  0);
        check({tag, "_hold"},  core_hold_o, 0);
    endtask

    // Full load transaction. phase: 0 = accepting, 1 = restart cycle, 2 = back to run.
    task automatic do_load(input logic [31:0] words[$], input bit use_last, input bit gaps);
        int n, acc, sent, phase, pulses, cyc, cnt_before;
        bit v, ready_exp;
        n = words.size(); acc = 0; sent = 0; phase = 0; pulses = 0; cyc = 0;
        hold_flag_i = 1'b0;
        ld_start_i  = 1'b1;
        ld_valid_i  = $urandom_range(0, 1);
        ld_data_i   = $urandom;
        ld_last_i   = 1'b0;
        tick;
        ld_start_i  = 1'b0;
        check("start_hold",  core_hold_o, 1);
        check("start_ready", ld_ready_o,  1);
        check("start_count", ld_count_o,  0);
        while (phase != 2 && cyc < 200) begin
            v           = (sent < n) && (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
            ld_valid_i  = v;
            ld_data_i   = (sent < n) ? words[sent] : $urandom;
            ld_last_i   = use_last && (sent == n - 1);
            ld_start_i  = $urandom_range(0, 1);
            inst_addr_i = 32'($urandom_range(0, DEPTH - 1)) << 2;
            ready_exp   = (phase == 0);
            tick;
            cyc++;
            if (phase == 1) phase = 2;
            if (v && ready_exp) begin
                model_mem[acc] = words[sent];
                acc++;
                if (ld_last_i || acc == DEPTH) phase = 1;
            end
            if (v) sent++;
            if (core_rst_o) pulses++;
            exp_inst = NOP; exp_valid = 1'b0; exp_err = 1'b0;
            check_read("load_read");
            check("load_count", ld_count_o,  acc);
            check("load_ready", ld_ready_o,  phase == 0);
            check("load_hold",  core_hold_o, phase != 2);
            check("load_rst",   core_rst_o,  phase == 1);
        end
        ld_start_i = 1'b0;
        check("load_timeout", phase == 2, 1);
        // Leftover stream words arrive after the load closed: they must be dropped.
        cnt_before = acc;
        while (sent < n) begin
            inst_addr_i = 32'($urandom_range(0, DEPTH - 1)) << 2;
            ld_valid_i  = 1'b1;
            ld_data_i   = words[sent];
            ld_last_i   = 1'b0;
            tick;
            sent++;
            ref_read(inst_addr_i, exp_inst, exp_valid, exp_err);
            check_read("drop_read");
            check("drop_count", ld_count_o, cnt_before);
            check("drop_ready", ld_ready_o, 0);
        end
        ld_valid_i = 1'b0;
        check("rst_pulses", pulses, 1);
        check("final_count", ld_count_o, acc);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] w0, w1, a;
        int n;
        bit ul;

        rst_n = 1'b0; inst_addr_i = '0; hold_flag_i = 1'b0;
        ld_start_i = 1'b0; ld_valid_i = 1'b0; ld_data_i = '0; ld_last_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        tick; tick;
        check("rst_inst",  inst_o,       NOP);
        check("rst_valid", inst_valid_o, 0);
        check("rst_err",   fetch_err_o,  0);
        check("rst_ready", ld_ready_o,   0);
        check("rst_count", ld_count_o,   0);
        check("rst_hold",  core_hold_o,  0);
        check("rst_crst",  core_rst_o,   0);
        #2 rst_n = 1'b1;
        tick;

        // Capacity: 10 words, no last marker -> 8 accepted, 2 dropped.
        q = {};
        for (int i = 0; i < 10; i++) q.push_back($urandom);
        do_load(q, 1'b0, 1'b0);
        check("cap_count", ld_count_o, DEPTH);
        for (int i = 0; i < DEPTH; i++) step_run(32'(i) << 2, 1'b0, "cap_fetch");

        // Fixed 4-word program with last marker.
        q = {32'h00100093, 32'h00200113, 32'h002081B3, 32'h0000006F};
        do_load(q, 1'b1, 1'b0);
        check("prog_count", ld_count_o, 4);
        for (int i = 0; i < 4; i++) step_run(32'(i) << 2, 1'b0, "prog_fetch");
        check("prog_word3", inst_o, 32'h0000006F);

        // Hold freezes the read outputs while the address moves.
        step_run(32'h4, 1'b0, "hold_pre");
        check("hold_pre_word", inst_o, 32'h00200113);
        for (int i = 0; i < 3; i++) step_run(32'h8, 1'b1, "hold_on");
        check("hold_kept", inst_o, 32'h00200113);
        step_run(32'h8, 1'b0, "hold_off");
        check("hold_release", inst_o, 32'h002081B3);

        // Misaligned / out-of-range fetches.
        step_run(32'h0000_0002, 1'b0, "range_mis");
        step_run(32'h0000_4000, 1'b0, "range_oob");

        // Reset in the middle of a load: two words written, then reset.
        w0 = $urandom; w1 = $urandom;
        ld_start_i = 1'b1; tick; ld_start_i = 1'b0;
        ld_valid_i = 1'b1; ld_data_i = w0; ld_last_i = 1'b0; tick; model_mem[0] = w0;
        ld_data_i = w1; tick; model_mem[1] = w1;
        check("mid_count", ld_count_o, 2);
        ld_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count", ld_count_o,  0);
        check("mid_rst_hold",  core_hold_o, 0);
        check("mid_rst_ready", ld_ready_o,  0);
        check("mid_rst_inst",  inst_o,      NOP);
        tick;
        #2 rst_n = 1'b1;
        tick;
        step_run(32'h0, 1'b0, "mid_fetch0");
        check("mid_word0", inst_o, w0);
        step_run(32'h4, 1'b0, "mid_fetch1");

        // Randomized loads (with gaps) followed by randomized fetch/hold traffic.
        for (int r = 0; r < 6; r++) begin
            ul = $urandom_range(0, 1);
            n  = ul ? $urandom_range(1, DEPTH) : $urandom_range(DEPTH, DEPTH + 3);
            q  = {};
            for (int i = 0; i < n; i++) q.push_back($urandom);
            do_load(q, ul, 1'b1);
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 3) == 0) a = $urandom;
                else a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
                step_run(a, $urandom_range(0, 3) == 0, "rnd_fetch");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
